// File: rtl/systolic_pkg.sv
// systolic_pkg -- definitions shared by the systolic array sequencer.
//   N_DEF, KW_DEF : default array dimension and k_len width
//   seq_state_t   : sequencer FSM state encoding
package systolic_pkg;

    localparam int N_DEF  = 4;
    localparam int KW_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/skew_mask_gen.sv
// skew_mask_gen -- diagonal feed mask for one edge of an N x N systolic array.
// Edge lane i carries real data for t = i .. i+k_len-1 and drives zero
// otherwise, which produces the skewed wavefront the array expects.
//   t     [CW-1:0] : feed cycle index
//   k_len [KW-1:0] : inner dimension
//   mask  [N-1:0]  : per-lane feed enable
module skew_mask_gen #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int CW = KW + 4
) (
    input  logic [CW-1:0] t,
    input  logic [KW-1:0] k_len,
    output logic [N-1:0]  mask
);

    // One extra bit so i + k_len cannot wrap.
    logic [CW:0] t_ext;
    assign t_ext = {1'b0, t};

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign mask[i] = (t_ext >= (CW+1)'(i)) &&
                         (t_ext <  ((CW+1)'(i) + (CW+1)'(k_len)));
    end

endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer -- control FSM for one N x N systolic matrix-multiply pass.
// Sequence: IDLE -> CLEAR (1 cycle) -> FEED (k_len+N-1 cycles) -> DRAIN (N
// cycles) -> OUT (N handshakes on res_valid/res_ready) -> IDLE with done.
//   clk, rst            : clock, synchronous active-high reset
//   start, k_len        : pass request and inner dimension (k_len=0 ignored)
//   abort               : cancel the running pass, no done pulse
//   busy                : not in IDLE
//   pe_clr              : clear all PE accumulators (CLEAR state)
//   feed_cnt            : feed cycle index t during FEED
//   row_en, col_en      : per-edge skewed feed enables
//   res_row, res_valid,
//   res_ready           : result row readout handshake
//   done                : one-cycle pulse on acceptance of the last row
//   perf_cycles         : busy cycles of the last pass
// Macro SYSTOLIC_PERF_EN enables the perf_cycles counter; otherwise it reads 0.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int KW = KW_DEF,
    parameter int CW = KW + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   abort,
    output logic                   busy,
    output logic                   pe_clr,
    output logic [CW-1:0]          feed_cnt,
    output logic [N-1:0]           row_en,
    output logic [N-1:0]           col_en,
    output logic [$clog2(N)-1:0]   res_row,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   done,
    output logic [31:0]            perf_cycles
);

    localparam int RW = $clog2(N);
    localparam int DW = $clog2(N) + 1;

    seq_state_t    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] t_q, t_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          pe_clr_q, pe_clr_d;
    logic          res_valid_q, res_valid_d;
    logic [N-1:0]  row_en_q, row_en_d;
    logic [N-1:0]  col_en_q, col_en_d;
    logic [N-1:0]  row_mask, col_mask;
    logic          feed_en;
    logic          accept;
    logic          last_row;
    logic [CW-1:0] last_t;

    assign accept   = (state_q == S_IDLE) && start && (k_len != '0) && !abort;
    assign last_row = (row_q == RW'(N-1));
    assign last_t   = CW'(k_q) + CW'(N-2);

    // Masks are computed from the next t so the enables can be registered
    // and line up with feed_cnt in the same cycle.
    skew_mask_gen #(.N(N), .KW(KW), .CW(CW)) u_row_mask (
        .t(t_d), .k_len(k_q), .mask(row_mask)
    );
    skew_mask_gen #(.N(N), .KW(KW), .CW(CW)) u_col_mask (
        .t(t_d), .k_len(k_q), .mask(col_mask)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        t_d         = '0;
        dcnt_d      = dcnt_q;
        row_d       = row_q;
        pe_clr_d    = 1'b0;
        res_valid_d = 1'b0;
        feed_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    k_d      = k_len;
                    state_d  = S_CLEAR;
                    pe_clr_d = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                feed_en = 1'b1;
            end
            S_FEED: begin
                if (t_q == last_t) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    t_d     = t_q + CW'(1);
                    feed_en = 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DW'(N-1)) begin
                    state_d     = S_OUT;
                    row_d       = '0;
                    res_valid_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_OUT: begin
                res_valid_d = 1'b1;
                if (res_ready) begin
                    if (last_row) begin
                        state_d     = S_IDLE;
                        row_d       = '0;
                        res_valid_d = 1'b0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition out of a non-IDLE state.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            t_d         = '0;
            dcnt_d      = '0;
            row_d       = '0;
            pe_clr_d    = 1'b0;
            res_valid_d = 1'b0;
            feed_en     = 1'b0;
        end
    end

    assign row_en_d = feed_en ? row_mask : '0;
    assign col_en_d = feed_en ? col_mask : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            t_q         <= '0;
            dcnt_q      <= '0;
            row_q       <= '0;
            pe_clr_q    <= 1'b0;
            res_valid_q <= 1'b0;
            row_en_q    <= '0;
            col_en_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            dcnt_q      <= dcnt_d;
            row_q       <= row_d;
            pe_clr_q    <= pe_clr_d;
            res_valid_q <= res_valid_d;
            row_en_q    <= row_en_d;
            col_en_q    <= col_en_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign pe_clr    = pe_clr_q;
    assign feed_cnt  = t_q;
    assign row_en    = row_en_q;
    assign col_en    = col_en_q;
    assign res_row   = row_q;
    assign res_valid = res_valid_q;
    // Pulses in the cycle whose edge accepts the last row and returns to IDLE.
    assign done      = (state_q == S_OUT) && res_ready && last_row && !abort && !rst;

`ifdef SYSTOLIC_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q != S_IDLE) begin
            perf_d = perf_q + 32'd1;
        end else if (accept) begin
            perf_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer -- randomized scoreboard bench for systolic_sequencer.
// The driver plans each pass from the pass timeline (clear, feed wavefront,
// drain, readout with planned stalls), pushes one expected record per busy
// cycle plus an end marker, then drives the pass. The monitor samples on the
// falling edge and pops/compares independently of the driver.
module tb_systolic_sequencer;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int CW = KW + 4;
    localparam int RW = $clog2(N);
`ifdef SYSTOLIC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort, res_ready;
    logic [KW-1:0] k_len;
    logic          busy, pe_clr, res_valid, done;
    logic [CW-1:0] feed_cnt;
    logic [N-1:0]  row_en, col_en;
    logic [RW-1:0] res_row;
    logic [31:0]   perf_cycles;

    systolic_sequencer #(.N(N), .KW(KW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .pe_clr(pe_clr), .feed_cnt(feed_cnt), .row_en(row_en),
        .col_en(col_en), .res_row(res_row), .res_valid(res_valid),
        .res_ready(res_ready), .done(done), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_end;
        logic          pe_clr;
        logic          chk_t;
        logic [CW-1:0] t;
        logic [N-1:0]  en;
        logic          res_valid;
        logic [RW-1:0] res_row;
        logic          done;
        logic [31:0]   perf;
        logic          full_zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t pass_recs[$];
    logic rdy_plan[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Build the expected timeline of one full pass.
    task automatic plan_pass(input int k, input int stall_row, input int stall_len);
        exp_t          e;
        logic [N-1:0]  fed[];
        int            s;
        pass_recs.delete();
        rdy_plan.delete();
        e = '{default: '0};
        e.pe_clr = 1'b1;
        pass_recs.push_back(e);
        rdy_plan.push_back(1'($urandom % 2));
        // Lane i receives its k operands during t = i .. i+k-1.
        fed = new[k + N - 1];
        foreach (fed[x]) fed[x] = '0;
        for (int i = 0; i < N; i++)
            for (int el = 0; el < k; el++)
                fed[i + el][i] = 1'b1;
        for (int t = 0; t < k + N - 1; t++) begin
            e = '{default: '0};
            e.chk_t = 1'b1;
            e.t     = CW'(t);
            e.en    = fed[t];
            pass_recs.push_back(e);
            rdy_plan.push_back(1'($urandom % 2));
        end
        for (int d = 0; d < N; d++) begin
            e = '{default: '0};
            pass_recs.push_back(e);
            rdy_plan.push_back(1'($urandom % 2));
        end
        for (int r = 0; r < N; r++) begin
            s = (r == stall_row) ? stall_len : int'($urandom_range(0, 2));
            for (int c = 0; c < s; c++) begin
                e = '{default: '0};
                e.res_valid = 1'b1;
                e.res_row   = RW'(r);
                pass_recs.push_back(e);
                rdy_plan.push_back(1'b0);
            end
            e = '{default: '0};
            e.res_valid = 1'b1;
            e.res_row   = RW'(r);
            e.done      = (r == N - 1);
            pass_recs.push_back(e);
            rdy_plan.push_back(1'b1);
        end
    endtask

    // mode: 0 complete, 1 abort at cut, 2 reset at cut (cut<0 = random).
    task automatic run_pass(input int k, input int stall_row, input int stall_len,
                            input int mode, input int cut);
        exp_t e;
        int   len;
        plan_pass(k, stall_row, stall_len);
        len = pass_recs.size();
        if (mode != 0) begin
            if (cut < 0 || cut >= len) cut = int'($urandom_range(0, len - 1));
            while (pass_recs.size() > cut + 1) void'(pass_recs.pop_back());
            e = pass_recs[cut];
            e.done = 1'b0;
            pass_recs[cut] = e;
            len = cut + 1;
        end
        foreach (pass_recs[x]) exp_q.push_back(pass_recs[x]);
        e = '{default: '0};
        e.is_end    = 1'b1;
        e.full_zero = (mode == 2);
        e.perf      = (PERF && mode != 2) ? 32'(len) : 32'd0;
        exp_q.push_back(e);
        start = 1'b1; k_len = KW'(k); abort = 1'b0;
        @(posedge clk); #1;
        for (int idx = 0; idx < len; idx++) begin
            res_ready = rdy_plan[idx];
            abort     = (mode == 1) && (idx == cut);
            rst       = (mode == 2) && (idx == cut);
            start     = ($urandom % 4 == 0);
            k_len     = KW'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; k_len = '0;
        res_ready = 1'($urandom % 2);
    endtask

    task automatic idle_gap(input int n);
        for (int c = 0; c < n; c++) begin
            start = ($urandom % 3 == 0);
            k_len = '0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        bit   prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (busy === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].is_end) begin
                        checks++; errors++;
                        $display("FAIL busy_overrun at %0t: got busy=1 expected busy=0", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pe_clr", 32'(pe_clr), 32'(e.pe_clr));
                        chk("row_en", 32'(row_en), 32'(e.en));
                        chk("col_en", 32'(col_en), 32'(e.en));
                        chk("res_valid", 32'(res_valid), 32'(e.res_valid));
                        chk("done", 32'(done), 32'(e.done));
                        if (e.chk_t) chk("feed_cnt", 32'(feed_cnt), 32'(e.t));
                        if (e.res_valid) chk("res_row", 32'(res_row), 32'(e.res_row));
                    end
                end else begin
                    chk("idle_done", 32'(done), 32'd0);
                    chk("idle_res_valid", 32'(res_valid), 32'd0);
                    chk("idle_en", 32'({pe_clr, row_en, col_en}), 32'd0);
                    if (prev_busy) begin
                        if (exp_q.size() != 0 && !exp_q[0].is_end) begin
                            checks++; errors++;
                            $display("FAIL early_idle at %0t: got busy=0 expected busy=1", $time);
                            while (exp_q.size() != 0 && !exp_q[0].is_end) void'(exp_q.pop_front());
                        end
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("perf_cycles", perf_cycles, e.perf);
                            if (e.full_zero) begin
                                chk("rst_feed_cnt", 32'(feed_cnt), 32'd0);
                                chk("rst_res_row", 32'(res_row), 32'd0);
                            end
                        end
                    end
                end
                prev_busy = (busy === 1'b1);
            end
        end
    end

    // Driver.
    initial begin
        int k, mode;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0; k_len = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_outs", 32'({pe_clr, row_en, col_en, res_valid, done}), 32'd0);
        chk("reset_feed_cnt", 32'(feed_cnt), 32'd0);
        chk("reset_res_row", 32'(res_row), 32'd0);
        chk("reset_perf", perf_cycles, 32'd0);
        mon_on = 1'b1;
        @(posedge clk); #1;

        run_pass(4, 0, 0, 0, 0);            // basic k=4 pass, no stalls on row 0
        idle_gap(1);
        run_pass(1, -1, 0, 0, 0);           // single-element wavefront
        idle_gap(2);
        run_pass(4, 2, 5, 0, 0);            // 5-cycle stall at row 2
        run_pass(4, -1, 0, 1, 4);           // abort at FEED t=3
        run_pass(3, -1, 0, 0, 0);           // restart right after abort
        idle_gap(1);
        run_pass(4, -1, 0, 2, 9);           // reset during DRAIN
        // start with k_len=0 is ignored
        start = 1'b1; k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("k0_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        run_pass(255, -1, 0, 0, 0);         // maximum inner dimension
        idle_gap(1);

        for (int p = 0; p < 40; p++) begin
            k = ($urandom % 8 == 0) ? int'($urandom_range(200, 255))
                                    : int'($urandom_range(1, 12));
            mode = int'($urandom % 10);
            mode = (mode == 0) ? 1 : (mode == 1) ? 2 : 0;
            run_pass(k, -1, 0, mode, -1);
            idle_gap(int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N PEs).
REQ-002 Parameter KW, default 8: width of k_len; maximum inner dimension is 2^KW-1.
REQ-003 Parameter CW, default KW+4: width of feed_cnt, sized to hold values up to k_len+N-2.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: request one matrix-multiply pass.
REQ-007 Port k_len, input, KW: inner dimension, sampled on start acceptance.
REQ-008 Port abort, input, 1: cancel the current pass.
REQ-009 Port busy, output, 1: high in every state except IDLE.
REQ-010 Port pe_clr, output, 1: clears all PE accumulators.
REQ-011 Port feed_cnt, output, CW: feed cycle index t, used by edge buffers to address row i / column j at t-i / t-j.
REQ-012 Port row_en and col_en, output, N each: per-edge feed enables; a low bit means the edge drives zero.
REQ-013 Port res_row, output, $clog2(N): PE result row being read out.
REQ-014 Port res_valid, output, 1; port res_ready, input, 1: readout handshake.
REQ-015 Port done, output, 1: one-cycle pulse at the end of a completed pass.
REQ-016 Port perf_cycles, output, 32: busy-cycle count of the last pass.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and OUT.
REQ-018 IDLE: start=1 with k_len!=0 SHALL latch k_len and enter CLEAR; start with k_len=0 is ignored; start in any other state is ignored.
REQ-019 CLEAR: exactly 1 cycle with pe_clr=1; then FEED with t=0.
REQ-020 FEED: t counts 0..k_len+N-2, one step per cycle; row_en[i]=(t>=i)&&(t<i+k_len), and col_en[j] uses the same rule with j; after the last t the FSM enters DRAIN.
REQ-021 DRAIN: exactly N cycles (N-1 for propagation plus 1 for accumulation), with row_en=col_en=0; then OUT with res_row=0.
REQ-022 OUT: res_valid=1; res_row increments on each cycle with res_valid&&res_ready.
REQ-023 On acceptance of row N-1, the FSM SHALL pulse done for 1 cycle and return to IDLE on the same edge.
REQ-024 res_ready held low SHALL stall OUT indefinitely with res_row stable.
REQ-025 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no done pulse; abort has priority over start and over state transitions.
REQ-026 Pass length SHALL be 1+(k_len+N-1)+N cycles, plus N handshake cycles minimum.
REQ-027 pe_clr, row_en, col_en and res_valid SHALL be registered outputs, valid in the cycle of their state.

Reset
REQ-028 rst=1 SHALL force IDLE and set every output to 0 (busy, pe_clr, feed_cnt, row_en, col_en, res_row, res_valid, done, perf_cycles) on the next edge, including mid-pass.
REQ-029 rst SHALL take priority over abort and start.

Configuration
REQ-030 Macro SYSTOLIC_PERF_EN: when defined, perf_cycles is cleared on start acceptance, increments each busy cycle, and holds its value in IDLE.
REQ-031 Without SYSTOLIC_PERF_EN, perf_cycles SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-032 A shared package systolic_pkg SHALL hold the FSM state enum seq_state_t and the default parameters N_DEF=4 and KW_DEF=8.
REQ-033 Skew-mask generation SHALL be a sub-module skew_mask_gen (inputs t and k_len; output an N-bit mask), instanced twice, for rows and columns.

Verification
REQ-034 N=4, k_len=4, start pulse, res_ready=1 -> pe_clr in cycle 1; FEED for 7 cycles; DRAIN for 4; res_row 0..3 over 4 cycles; done in the last OUT cycle; perf_cycles=16 with SYSTOLIC_PERF_EN defined.
REQ-035 N=4, k_len=1 -> FEED t=0..3 with row_en sequence 0001, 0010, 0100, 1000.
REQ-036 res_ready=0 for 5 cycles in OUT at res_row=2 -> res_row stays 2 and res_valid stays 1; done is delayed by 5 cycles.
REQ-037 abort at FEED t=3 -> busy=0 next cycle, no done pulse; a new start is accepted the cycle after that.
REQ-038 rst during DRAIN -> all outputs 0 on the next edge; start with k_len=0 in IDLE -> busy stays 0.
